// File: rtl/line_acc_pkg.sv
// Shared types and width helper for the multi-channel line accumulator.
package line_acc_pkg;

  typedef enum logic {ACC_SUM = 1'b0, ACC_MAX = 1'b1} acc_mode_e;
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  // Wide enough to hold max_lines all-ones line sums without wrapping.
  function automatic int acc_width(input int line_w, input int max_lines);
    return line_w + $clog2(max_lines);
  endfunction

endpackage

// File: rtl/multi_channel_line_accumulator_channel.sv
// One channel's accumulator: load on first line, sum or max on later lines.
module line_acc_channel
  import line_acc_pkg::*;
#(
  parameter int LINE_SUM_W = 12,
  parameter int ACC_W      = 15
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  update,
  input  acc_mode_e             mode,
  input  logic [LINE_SUM_W-1:0] line_sum,
  output logic [ACC_W-1:0]      acc_next
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] line_ext;

  assign line_ext = ACC_W'(line_sum);

  // acc_next already includes the current line so the top can capture a
  // completed frame on the same edge that accepts its last line.
  always_comb begin
    acc_next = acc_q;
    if (load) begin
      acc_next = line_ext;
    end else if (update) begin
      if (mode == ACC_MAX) acc_next = (line_ext > acc_q) ? line_ext : acc_q;
      else                 acc_next = acc_q + line_ext;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_next;
  end

endmodule

// File: rtl/multi_channel_line_accumulator.sv
// Per-channel frame accumulator over a runtime-programmable number of lines.
//   state | meaning
//   IDLE  | no lines of the current frame held
//   ACCUM | 1..N-1 lines held, N latched on the first line
module multi_channel_line_accumulator
  import line_acc_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int LINE_SIZE    = 64,
  parameter int PIXEL_SIZE   = 8,
  parameter int NUM_OF_LINES = 1024,
  parameter int LINE_SUM_W   = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
  parameter int MAX_LINES    = NUM_OF_LINES,
  localparam int ACC_W       = acc_width(LINE_SUM_W, MAX_LINES),
  localparam int CNT_W       = $clog2(MAX_LINES + 1)
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         line_valid,
  input  logic [NUM_CH*LINE_SUM_W-1:0] line_sum,
  input  logic                         frame_start,
  input  logic [CNT_W-1:0]             num_lines,
  input  logic                         acc_mode,
  output logic [NUM_CH*ACC_W-1:0]      frame_sum,
  output logic                         frame_done,
  output logic                         frame_abort,
  output logic                         busy,
  output logic [CNT_W-1:0]             line_count
);

  state_e            state_q, state_d;
  acc_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0]  n_q, n_d, n_eff;
  logic [CNT_W-1:0]  count_q, count_d, cnt_inc;
  logic              first, upd, complete, abort_d;
  logic [NUM_CH*ACC_W-1:0] acc_next;

  always_comb begin
    n_eff    = (num_lines == '0 || num_lines > CNT_W'(MAX_LINES)) ? CNT_W'(MAX_LINES) : num_lines;
    first    = line_valid && (state_q == IDLE || frame_start);
    upd      = line_valid && (state_q == ACCUM) && !frame_start;
    cnt_inc  = count_q + CNT_W'(1);
    complete = (first && n_eff == CNT_W'(1)) || (upd && cnt_inc == n_q);
    // A restart that also completes a one-line frame reports done only.
    abort_d  = frame_start && (state_q == ACCUM) && !complete;
    state_d  = state_q;
    count_d  = count_q;
    n_d      = n_q;
    mode_d   = mode_q;
    if (first) begin
      n_d     = n_eff;
      mode_d  = acc_mode_e'(acc_mode);
      count_d = CNT_W'(1);
      state_d = ACCUM;
    end else if (upd) begin
      count_d = cnt_inc;
    end else if (abort_d) begin
      count_d = '0;
      state_d = IDLE;
    end
    if (complete) begin
      count_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= ACC_SUM;
      n_q         <= '0;
      count_q     <= '0;
      frame_sum   <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      count_q     <= count_d;
      frame_done  <= complete;
      frame_abort <= abort_d;
      if (complete) frame_sum <= acc_next;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    line_acc_channel #(
      .LINE_SUM_W (LINE_SUM_W),
      .ACC_W      (ACC_W)
    ) u_ch (
      .CLK      (CLK),
      .reset    (reset),
      .load     (first),
      .update   (upd),
      .mode     (mode_q),
      .line_sum (line_sum[c*LINE_SUM_W +: LINE_SUM_W]),
      .acc_next (acc_next[c*ACC_W +: ACC_W])
    );
  end

  assign busy       = (state_q == ACCUM);
  assign line_count = count_q;

endmodule

// File: tb/tb_multi_channel_line_accumulator.sv
// Randomized and directed bench for the multi-channel line accumulator.
module tb_multi_channel_line_accumulator;

  localparam int LW = 12;
  localparam int AW = 15;
  localparam int ML = 8;
  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            reset = 1'b0;
  logic            line_valid = 1'b0;
  logic [2*LW-1:0] line_sum = '0;
  logic            frame_start = 1'b0;
  logic [CW-1:0]   num_lines = '0;
  logic            acc_mode = 1'b0;
  logic [2*AW-1:0] frame_sum;
  logic            frame_done, frame_abort, busy;
  logic [CW-1:0]   line_count;

  int checks = 0;
  int errors = 0;

  // Reference model: lines of the open frame kept as plain lists.
  int unsigned q0[$], q1[$];
  int unsigned m_sum0 = 0, m_sum1 = 0;
  int          m_n = 0;
  bit          m_mode = 0;
  bit          exp_done = 0, exp_abort = 0;

  multi_channel_line_accumulator #(
    .NUM_CH(2), .LINE_SIZE(16), .PIXEL_SIZE(4), .NUM_OF_LINES(8)
  ) dut (
    .CLK(CLK), .reset(reset), .line_valid(line_valid), .line_sum(line_sum),
    .frame_start(frame_start), .num_lines(num_lines), .acc_mode(acc_mode),
    .frame_sum(frame_sum), .frame_done(frame_done), .frame_abort(frame_abort),
    .busy(busy), .line_count(line_count)
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned reduce(input int unsigned q[$], input bit md);
    int unsigned r = 0;
    foreach (q[k]) r = md ? ((q[k] > r) ? q[k] : r) : r + q[k];
    return r;
  endfunction

  function automatic logic [2*AW-1:0] exp_fs();
    logic [AW-1:0] a0, a1;
    a0 = AW'(m_sum0);
    a1 = AW'(m_sum1);
    return {a1, a0};
  endfunction

  task automatic model_step(bit v, bit fs, int nl, bit md, int unsigned l0, int unsigned l1);
    exp_done = 0;
    exp_abort = 0;
    if (fs && q0.size() > 0) begin
      exp_abort = 1;
      q0.delete();
      q1.delete();
    end
    if (v) begin
      if (q0.size() == 0) begin
        m_n = (nl == 0 || nl > ML) ? ML : nl;
        m_mode = md;
      end
      q0.push_back(l0);
      q1.push_back(l1);
      if (q0.size() == m_n) begin
        m_sum0 = reduce(q0, m_mode);
        m_sum1 = reduce(q1, m_mode);
        exp_done = 1;
        q0.delete();
        q1.delete();
      end
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_sum0 = 0;
    m_sum1 = 0;
    exp_done = 0;
    exp_abort = 0;
  endtask

  task automatic drive(bit v, bit fs, int nl, bit md, int unsigned l0, int unsigned l1);
    logic [LW-1:0] s0, s1;
    s0 = LW'(l0);
    s1 = LW'(l1);
    line_valid  = v;
    frame_start = fs;
    num_lines   = CW'(nl);
    acc_mode    = md;
    line_sum    = {s1, s0};
    @(posedge CLK);
    #1;
    model_step(v, fs, nl, md, l0, l1);
    line_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    checks += 5;
    if (frame_sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", frame_sum); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (line_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", line_count); end
  endtask

  task automatic test_sum_basic();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 4, 0, i, 10 * i);
      checks++;
      if (frame_done !== (i == 4)) begin
        errors++; $display("FAIL sum_done line=%0d got=%b exp=%b", i, frame_done, (i == 4));
      end
      checks++;
      if (busy !== (i < 4)) begin errors++; $display("FAIL sum_busy line=%0d got=%b exp=%b", i, busy, (i < 4)); end
    end
    checks++;
    if (frame_sum !== {15'd100, 15'd10}) begin
      errors++; $display("FAIL sum_result got=%h exp=%h", frame_sum, {15'd100, 15'd10});
    end
    drive(0, 0, 4, 0, 0, 0);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL sum_done_pulse got=%b exp=0", frame_done); end
  endtask

  task automatic test_max_mode();
    drive(1, 0, 3, 1, 5, 7);
    drive(1, 0, 0, 0, 9, 3);
    drive(1, 0, 0, 0, 2, 1);
    checks += 3;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL max_done got=%b exp=1", frame_done); end
    if (frame_sum[AW-1:0] !== 15'd9) begin errors++; $display("FAIL max_ch0 got=%0d exp=9", frame_sum[AW-1:0]); end
    if (frame_sum[2*AW-1:AW] !== 15'd7) begin errors++; $display("FAIL max_ch1 got=%0d exp=7", frame_sum[2*AW-1:AW]); end
    drive(1, 0, 2, 0, 5, 4);
    drive(1, 0, 3, 1, 9, 4);
    checks++;
    if (frame_sum !== {15'd8, 15'd14}) begin
      errors++; $display("FAIL mode_next_frame got=%h exp=%h", frame_sum, {15'd8, 15'd14});
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < ML; i++) drive(1, 0, 0, 0, 4095, 4095);
    checks += 2;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL ones_done got=%b exp=1", frame_done); end
    if (frame_sum !== {15'd32760, 15'd32760}) begin
      errors++; $display("FAIL ones_sum got=%h exp=%h", frame_sum, {15'd32760, 15'd32760});
    end
  endtask

  task automatic test_restart();
    logic [2*AW-1:0] prev;
    prev = exp_fs();
    drive(1, 0, 4, 0, 1, 1);
    drive(1, 0, 4, 0, 2, 2);
    drive(1, 1, 4, 0, 7, 8);
    checks += 4;
    if (frame_abort !== 1'b1) begin errors++; $display("FAIL restart_abort got=%b exp=1", frame_abort); end
    if (frame_sum !== prev) begin errors++; $display("FAIL restart_hold got=%h exp=%h", frame_sum, prev); end
    if (line_count !== 4'd1) begin errors++; $display("FAIL restart_count got=%0d exp=1", line_count); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL restart_nodone got=%b exp=0", frame_done); end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 4, 0, 10 * i, i);
      checks++;
      if (frame_done !== (i == 3)) begin
        errors++; $display("FAIL restart_done line=%0d got=%b exp=%b", i, frame_done, (i == 3));
      end
    end
    checks++;
    if (frame_sum !== {15'd14, 15'd67}) begin
      errors++; $display("FAIL restart_sum got=%h exp=%h", frame_sum, {15'd14, 15'd67});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 100 + i, 200 + i);
      checks += 3;
      if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done i=%0d got=%b exp=1", i, frame_done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy i=%0d got=%b exp=0", i, busy); end
      if (frame_sum !== exp_fs()) begin errors++; $display("FAIL b2b_sum i=%0d got=%h exp=%h", i, frame_sum, exp_fs()); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 4, 0, 3, 3);
    drive(1, 0, 4, 0, 4, 4);
    reset = 1'b0;
    #2;
    model_clear();
    checks += 4;
    if (frame_sum !== '0) begin errors++; $display("FAIL midrst_sum got=%h exp=0", frame_sum); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (line_count !== '0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", line_count); end
    if (frame_abort !== 1'b0) begin errors++; $display("FAIL midrst_abort got=%b exp=0", frame_abort); end
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) drive(1, 0, 4, 0, i * 3, i * 5);
    checks += 2;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b exp=1", frame_done); end
    if (frame_sum !== {15'd50, 15'd30}) begin
      errors++; $display("FAIL midrst_sum2 got=%h exp=%h", frame_sum, {15'd50, 15'd30});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit v, fs, md;
      int nl;
      int unsigned l0, l1;
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 15) == 0);
      md = $urandom_range(0, 1);
      nl = $urandom_range(0, 9);
      if (fs && v && nl == 1) nl = 2;
      l0 = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 4095);
      l1 = $urandom_range(0, 4095);
      drive(v, fs, nl, md, l0, l1);
      checks += 5;
      if (frame_done !== exp_done) begin errors++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", i, frame_done, exp_done); end
      if (frame_abort !== exp_abort) begin errors++; $display("FAIL rand_abort cyc=%0d got=%b exp=%b", i, frame_abort, exp_abort); end
      if (busy !== (q0.size() > 0)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, (q0.size() > 0)); end
      if (line_count !== CW'(q0.size())) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, line_count, q0.size()); end
      if (frame_sum !== exp_fs()) begin errors++; $display("FAIL rand_sum cyc=%0d got=%h exp=%h", i, frame_sum, exp_fs()); end
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    test_reset();
    reset = 1'b1;
    test_sum_basic();
    test_max_mode();
    test_all_ones();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_line_accumulator.md
# multi_channel_line_accumulator

Parametrised successor to the single-channel line-sum accumulator. Accumulates per-line sums for NUM_CH independent channels over a runtime-programmable number of lines per frame. Supports sum or peak (max) mode, a valid handshake on input, an explicit frame restart, and a registered, held frame result with a one-cycle done pulse. Sits between the per-line sum stage and the frame-statistics consumer.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels
- LINE_SUM_W, $clog2(LINE_SIZE)+2*PIXEL_SIZE, width of one channel's line sum
- MAX_LINES, NUM_OF_LINES, maximum lines per frame; sizes counter and accumulator
- ACC_W, LINE_SUM_W+$clog2(MAX_LINES), derived accumulator and result width; not overridden

Ports:
- CLK  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- line_valid  in  1  line_sum carries a valid line this cycle
- line_sum  in  NUM_CH x LINE_SUM_W  per-channel line sums, packed, channel 0 in LSBs
- frame_start  in  1  synchronous restart; discards any partial frame
- num_lines  in  $clog2(MAX_LINES+1)  lines per frame; sampled on the first accepted line of each frame
- acc_mode  in  1  0 = sum, 1 = max; sampled with num_lines
- frame_sum  out  NUM_CH x ACC_W  last completed frame result per channel, held
- frame_done  out  1  one-cycle pulse: frame_sum updated
- frame_abort  out  1  one-cycle pulse: partial frame discarded
- busy  out  1  at least one line of the current frame accepted
- line_count  out  $clog2(MAX_LINES+1)  lines accepted in the current frame

## Operation
- FSM states:
  - IDLE: no lines held.
  - ACCUM: 1..N-1 lines held, where N is the latched line count.
- IDLE, line_valid=1:
  - Latch N from num_lines; num_lines=0 or >MAX_LINES latches MAX_LINES.
  - Latch mode from acc_mode.
  - Load accumulators with zero-extended line_sum; set count to 1.
  - If N=1, complete the frame immediately and remain in IDLE.
  - Otherwise go to ACCUM.
- ACCUM, line_valid=1:
  - Sum mode: acc += line_sum. Max mode: acc = max(acc, line_sum), unsigned compare.
  - Increment count.
  - When count reaches N, complete the frame and go to IDLE.
- Frame completion:
  - frame_sum <= final accumulator values, computed including the completing line.
  - frame_done pulses.
  - count returns to 0.
- line_valid=0: no state change.
- frame_start in ACCUM:
  - Pulse frame_abort; frame_sum is left unchanged.
  - If line_valid=1 in the same cycle, that line is the first line of the new frame; IDLE first-line rules apply, including re-latching N and mode.
  - Otherwise go to IDLE.
- frame_start in IDLE: no abort pulse; a same-cycle line_valid is accepted normally.
- Arithmetic is unsigned. ACC_W guarantees no overflow for up to MAX_LINES lines; no saturation logic.
- num_lines and acc_mode changes mid-frame are ignored until the next frame.

## Timing
- All outputs registered.
- Reset values: frame_sum=0, frame_done=0, frame_abort=0, busy=0, line_count=0, FSM=IDLE.
- Latency: frame_done and the new frame_sum appear on the clock edge that accepts line N, i.e. visible the cycle after line N is presented.
- Back-to-back: the first line of the next frame may arrive the cycle after the last line; no bubble required.
- Throughput: one line per cycle.
- busy=1 exactly in ACCUM.
- line_count reflects accepted lines after each edge.
- Reset assertion mid-frame: immediate return to reset values; partial data lost; no abort pulse.
- frame_done and frame_abort never assert in the same cycle.

## Structure
- Package line_acc_pkg holds:
  - acc_mode_e {ACC_SUM, ACC_MAX}
  - state_e {IDLE, ACCUM}
  - function acc_width(line_w, max_lines)
- Shared width constants (LINE_SIZE, PIXEL_SIZE, NUM_OF_LINES) remain in Parameters.svh.
- Sub-module line_acc_channel: one channel's accumulator register and sum/max datapath, with load/update controls. It is generated NUM_CH times under the common FSM/counter in the top.

## Test plan
- NUM_CH=2, num_lines=4, sum mode; ch0 lines 1,2,3,4 and ch1 lines 10,20,30,40 -> frame_sum={100,10}, frame_done one pulse on the edge after the fourth line.
- Max mode, num_lines=3; ch0 lines 5,9,2 -> ch0 result 9; then switch acc_mode mid-frame -> no effect until the next frame.
- All-ones line_sum for MAX_LINES lines, num_lines=0 -> result equals MAX_LINES*(2^LINE_SUM_W-1) exactly, with no wrap.
- frame_start together with line_valid after 2 of 4 lines -> frame_abort pulse, previous frame_sum unchanged, line_count=1, new frame completes 3 lines later.
- num_lines=1 with continuous line_valid -> frame_done high every cycle, busy stays 0.
- reset driven low after 2 lines -> all outputs 0 asynchronously; after reset is released, a fresh 4-line frame sums correctly.
